mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: single memory port shared by I-cache fills, D-cache fills and D stores.
// Define MEM_ARBITER_RR_EN for round-robin between the D and I request classes.
module mem_arbiter #(
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LAT     = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_miss,
    input  logic [15:0]                    i_addr,
    input  logic                           d_miss,
    input  logic                           d_wr,
    input  logic [15:0]                    d_addr,
    input  logic [15:0]                    d_wdata,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [15:0]                    mem_addr,
    output logic [15:0]                    mem_wdata,
    input  logic [15:0]                    mem_rdata,
    input  logic                           mem_rvalid,
    output logic                           i_fill_valid,
    output logic                           d_fill_valid,
    output logic [15:0]                    fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic                           i_done,
    output logic                           d_done,
    output logic                           busy
);

    localparam int          WW      = $clog2(BLOCK_WORDS);
    localparam logic [15:0] MASK    = ~16'(2 * BLOCK_WORDS - 1);
    localparam logic [WW:0] N_ISSUE = (WW + 1)'(BLOCK_WORDS);
    localparam logic [WW-1:0] W_LAST = WW'(BLOCK_WORDS - 1);

    if (BLOCK_WORDS < 2 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0 || MEM_LAT < 1)
    begin : g_bad_cfg
        $error("mem_arbiter: unsupported parameters");
    end

    typedef enum logic [2:0] {IDLE, FILL_I, FILL_D, STORE, DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WW:0]     r_issue;
    logic [WW-1:0]   r_ret;
    logic [15:0]     r_base;
    logic            w_fill;
    logic            w_issue;
    logic            w_last;
    logic            w_d_req;
    logic            w_grant_d;

    assign w_d_req = d_miss | d_wr;

`ifdef MEM_ARBITER_RR_EN
    logic r_last_d;

    // Reset value "I granted last" lets D win the first contested grant.
    assign w_grant_d = w_d_req & (~i_miss | ~r_last_d);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_d <= 1'b0;
        end else if (r_state == IDLE && w_next != IDLE) begin
            r_last_d <= w_grant_d;
        end
    end
`else
    assign w_grant_d = w_d_req;
`endif

    assign w_fill  = (r_state == FILL_I) || (r_state == FILL_D);
    assign w_issue = w_fill && (r_issue < N_ISSUE);
    assign w_last  = w_fill && mem_rvalid && (r_ret == W_LAST);
    assign busy    = (r_state != IDLE);

    always_comb begin
        w_next       = r_state;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        fill_data    = '0;
        fill_word    = '0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next = d_miss ? FILL_D : STORE;
                end else if (i_miss) begin
                    w_next = FILL_I;
                end
            end
            FILL_I, FILL_D: begin
                mem_en = w_issue;
                if (w_issue) begin
                    mem_addr = r_base + 16'({r_issue, 1'b0});
                end
                // Returns are counted apart from issues; reads stay pipelined.
                if (mem_rvalid) begin
                    i_fill_valid = (r_state == FILL_I);
                    d_fill_valid = (r_state == FILL_D);
                    fill_data    = mem_rdata;
                    fill_word    = r_ret;
                end
                if (w_last) begin
                    i_done = (r_state == FILL_I);
                    d_done = (r_state == FILL_D);
                    w_next = DONE;
                end
            end
            STORE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_done    = 1'b1;
                w_next    = DONE;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_issue <= '0;
            r_ret   <= '0;
            r_base  <= '0;
        end else begin
            r_state <= w_next;
            if (w_fill) begin
                if (w_issue) begin
                    r_issue <= r_issue + 1'b1;
                end
                if (mem_rvalid) begin
                    r_ret <= r_ret + 1'b1;
                end
            end else begin
                r_issue <= '0;
                r_ret   <= '0;
            end
            if (r_state == IDLE) begin
                r_base <= (w_grant_d ? d_addr : i_addr) & MASK;
            end
        end
    end

endmodule
